// File: rtl/rob_pkg.sv
// Shared types and helpers for the multi-port reorder buffer.
//
// Contents:
//   DEF_*         default parameter values for rob_multiport
//   ptr_t         {wrap, idx} pointer layout at the default depth
//   entry_t       per-entry control bits (the payload is stored beside it,
//                 because its width is a parameter of the top module)
//   age_in_range  wrap-aware test of ptr in [head, tail)
//
// Optional feature macro: ROB_WB_DATA_EN (used by rob_multiport only).
package rob_pkg;

  localparam int DEF_ROB_DEPTH    = 64;
  localparam int DEF_DECODE_WIDTH = 2;
  localparam int DEF_COMMIT_WIDTH = 2;
  localparam int DEF_WB_PORTS     = 5;
  localparam int DEF_PAYLOAD_W    = 64;
  localparam int DEF_IW           = $clog2(DEF_ROB_DEPTH);

  typedef struct packed {
    logic              wrap;
    logic [DEF_IW-1:0] idx;
  } ptr_t;

  typedef struct packed {
    logic complete;
    logic excp;
    logic redirect;
    logic serial;
  } entry_t;

  // Pointers are ptr_w bits wide ({wrap, idx}). Distances are taken modulo
  // 2^ptr_w, so the wrap bit makes full and empty distinguishable and the
  // test is just "distance from head is below occupancy".
  function automatic logic age_in_range(input logic [31:0] ptr,
                                        input logic [31:0] head,
                                        input logic [31:0] tail,
                                        input int unsigned ptr_w);
    logic [31:0] mask;
    logic [31:0] off_p;
    logic [31:0] off_t;
    mask  = (32'd1 << ptr_w) - 32'd1;
    off_p = (ptr - head) & mask;
    off_t = (tail - head) & mask;
    return off_p < off_t;
  endfunction

endpackage

// File: rtl/rob_commit_sel.sv
// Commit slot selector for the reorder buffer (purely combinational).
//
// Ports:
//   i_count     occupied entries in the ROB
//   i_complete  per-slot complete flag of entry head+i
//   i_excp      per-slot exception flag
//   i_redirect  per-slot redirect flag
//   i_serial    per-slot commit-alone flag
//   o_valid     prefix-contiguous commit mask
//
// An entry carrying excp, redirect or serial commits only in slot 0 and
// blocks every later slot in the same cycle.
module rob_commit_sel #(
  parameter int COMMIT_WIDTH = 2,
  parameter int CNT_W        = 7
) (
  input  logic [CNT_W-1:0]        i_count,
  input  logic [COMMIT_WIDTH-1:0] i_complete,
  input  logic [COMMIT_WIDTH-1:0] i_excp,
  input  logic [COMMIT_WIDTH-1:0] i_redirect,
  input  logic [COMMIT_WIDTH-1:0] i_serial,
  output logic [COMMIT_WIDTH-1:0] o_valid
);

  logic w_chain;
  logic w_special;

  always_comb begin
    o_valid   = '0;
    w_chain   = 1'b1;
    w_special = 1'b0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      w_special  = i_excp[i] | i_redirect[i] | i_serial[i];
      o_valid[i] = w_chain & (CNT_W'(i) < i_count) & i_complete[i] &
                   ((i == 0) | ~w_special);
      // A special entry in slot 0 ends the group after itself.
      w_chain    = o_valid[i] & ~w_special;
    end
  end

endmodule

// File: rtl/rob_multiport.sv
// Parametrised reorder buffer between rename/dispatch and commit.
//
// Ports (pointers are {wrap bit, index}, IW+1 bits):
//   clk, rst          clock, synchronous active-high reset
//   flush_i           empties the ROB (head = tail = 0)
//   alloc_*           allocation: valid mask (contiguous from bit 0), payload,
//                     front-end exception, serial flag; alloc_ready_o and
//                     alloc_ptr_o (tail + i) go back to rename
//   wb_*              write-back ports: valid, target ptr, excp, redirect,
//                     head-only; wb_ready_o per port
//   squash_*          selective squash, squash_ptr_i is youngest survivor
//   cmt_*             commit slots: valid mask, ptr, payload, excp, redirect
//   count_o, empty_o  occupancy
//
// Optional feature: define ROB_WB_DATA_EN to add wb_we_i/wb_data_i and
// cmt_we_o/cmt_wdata_o with per-entry we/data storage (written at
// write-back, cleared at allocation).
//
// Handshakes: allocation fires when alloc_ready_o & alloc_ready_i and no
// squash/flush is present, and alloc_ready_o depends on registered state
// only. A write-back is taken when wb_valid_i & wb_ready_o; a taken
// write-back whose pointer is outside [head, tail) is dropped silently.
// Commit has no back-pressure: every cmt_valid_o slot retires this cycle.
module rob_multiport
  import rob_pkg::*;
#(
  parameter int ROB_DEPTH    = DEF_ROB_DEPTH,
  parameter int DECODE_WIDTH = DEF_DECODE_WIDTH,
  parameter int COMMIT_WIDTH = DEF_COMMIT_WIDTH,
  parameter int WB_PORTS     = DEF_WB_PORTS,
  parameter int PAYLOAD_W    = DEF_PAYLOAD_W,
  localparam int IW          = $clog2(ROB_DEPTH),
  localparam int PW          = IW + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush_i,
  input  logic [DECODE_WIDTH-1:0]        alloc_valid_i,
  input  logic                           alloc_ready_i,
  input  logic [DECODE_WIDTH*PAYLOAD_W-1:0] alloc_payload_i,
  input  logic [DECODE_WIDTH-1:0]        alloc_excp_i,
  input  logic [DECODE_WIDTH-1:0]        alloc_serial_i,
  output logic                           alloc_ready_o,
  output logic [DECODE_WIDTH*PW-1:0]     alloc_ptr_o,
  input  logic [WB_PORTS-1:0]            wb_valid_i,
  input  logic [WB_PORTS*PW-1:0]         wb_ptr_i,
  input  logic [WB_PORTS-1:0]            wb_excp_i,
  input  logic [WB_PORTS-1:0]            wb_redirect_i,
  input  logic [WB_PORTS-1:0]            wb_head_only_i,
  output logic [WB_PORTS-1:0]            wb_ready_o,
  input  logic                           squash_valid_i,
  input  logic [PW-1:0]                  squash_ptr_i,
  output logic [COMMIT_WIDTH-1:0]        cmt_valid_o,
  output logic [COMMIT_WIDTH*PW-1:0]     cmt_ptr_o,
  output logic [COMMIT_WIDTH*PAYLOAD_W-1:0] cmt_payload_o,
  output logic [COMMIT_WIDTH-1:0]        cmt_excp_o,
  output logic [COMMIT_WIDTH-1:0]        cmt_redirect_o,
  output logic [PW-1:0]                  count_o,
  output logic                           empty_o
`ifdef ROB_WB_DATA_EN
  ,
  input  logic [WB_PORTS-1:0]            wb_we_i,
  input  logic [WB_PORTS*32-1:0]         wb_data_i,
  output logic [COMMIT_WIDTH-1:0]        cmt_we_o,
  output logic [COMMIT_WIDTH*32-1:0]     cmt_wdata_o
`endif
);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [PW-1:0]        r_head;
  logic [PW-1:0]        r_tail;
  entry_t               r_ent     [ROB_DEPTH];
  logic [PAYLOAD_W-1:0] r_payload [ROB_DEPTH];

  logic [PW-1:0]           w_count;
  logic                    w_alloc_ready;
  logic                    w_alloc_fire;
  logic [PW-1:0]           w_alloc_cnt;
  logic [PW-1:0]           w_alloc_ptr  [DECODE_WIDTH];
  logic [PW-1:0]           w_wb_ptr     [WB_PORTS];
  logic [WB_PORTS-1:0]     w_wb_ready;
  logic [WB_PORTS-1:0]     w_wb_accept;
  logic [PW-1:0]           w_cmt_ptr    [COMMIT_WIDTH];
  logic [IW-1:0]           w_cmt_idx    [COMMIT_WIDTH];
  logic [COMMIT_WIDTH-1:0] w_slot_complete;
  logic [COMMIT_WIDTH-1:0] w_slot_excp;
  logic [COMMIT_WIDTH-1:0] w_slot_redirect;
  logic [COMMIT_WIDTH-1:0] w_slot_serial;
  logic [COMMIT_WIDTH-1:0] w_cmt_valid;
  logic [PW-1:0]           w_cmt_cnt;

  // Modulo 2*ROB_DEPTH subtraction; the wrap bit separates full from empty.
  assign w_count       = r_tail - r_head;
  assign w_alloc_ready = (w_count <= PW'(ROB_DEPTH - DECODE_WIDTH));
  assign w_alloc_fire  = w_alloc_ready & alloc_ready_i & ~squash_valid_i & ~flush_i;

  assign alloc_ready_o = w_alloc_ready;
  assign count_o       = w_count;
  assign empty_o       = (w_count == '0);

  // ---------------------------------------------------------------------
  // Allocation pointers
  // ---------------------------------------------------------------------
  always_comb begin
    alloc_ptr_o = '0;
    w_alloc_cnt = '0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      w_alloc_ptr[i]              = r_tail + PW'(i);
      alloc_ptr_o[i*PW +: PW]     = w_alloc_ptr[i];
      if (alloc_valid_i[i]) begin
        w_alloc_cnt = w_alloc_cnt + PW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Write-back acceptance
  // ---------------------------------------------------------------------
  always_comb begin
    for (int p = 0; p < WB_PORTS; p++) begin
      w_wb_ptr[p]    = wb_ptr_i[p*PW +: PW];
      w_wb_ready[p]  = ~wb_head_only_i[p] | (w_wb_ptr[p] == r_head);
      // Range check drops write-backs aimed at squashed or freed entries.
      w_wb_accept[p] = wb_valid_i[p] & w_wb_ready[p] &
                       age_in_range(32'(w_wb_ptr[p]), 32'(r_head), 32'(r_tail), PW);
    end
  end

  assign wb_ready_o = w_wb_ready;

  // ---------------------------------------------------------------------
  // Commit slots (read from registered entries only)
  // ---------------------------------------------------------------------
  always_comb begin
    cmt_ptr_o      = '0;
    cmt_payload_o  = '0;
    cmt_excp_o     = '0;
    cmt_redirect_o = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      w_cmt_ptr[i]       = r_head + PW'(i);
      w_cmt_idx[i]       = w_cmt_ptr[i][IW-1:0];
      w_slot_complete[i] = r_ent[w_cmt_idx[i]].complete;
      w_slot_excp[i]     = r_ent[w_cmt_idx[i]].excp;
      w_slot_redirect[i] = r_ent[w_cmt_idx[i]].redirect;
      w_slot_serial[i]   = r_ent[w_cmt_idx[i]].serial;
      cmt_ptr_o[i*PW +: PW]                   = w_cmt_ptr[i];
      cmt_payload_o[i*PAYLOAD_W +: PAYLOAD_W] = r_payload[w_cmt_idx[i]];
      cmt_excp_o[i]                           = w_slot_excp[i];
      cmt_redirect_o[i]                       = w_slot_redirect[i];
    end
  end

  rob_commit_sel #(
    .COMMIT_WIDTH (COMMIT_WIDTH),
    .CNT_W        (PW)
  ) u_commit_sel (
    .i_count    (w_count),
    .i_complete (w_slot_complete),
    .i_excp     (w_slot_excp),
    .i_redirect (w_slot_redirect),
    .i_serial   (w_slot_serial),
    .o_valid    (w_cmt_valid)
  );

  assign cmt_valid_o = w_cmt_valid;

  always_comb begin
    w_cmt_cnt = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (w_cmt_valid[i]) begin
        w_cmt_cnt = w_cmt_cnt + PW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Head / tail
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (flush_i) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      // Commit keeps retiring during a squash; the squash point never commits.
      r_head <= r_head + w_cmt_cnt;
      if (squash_valid_i) begin
        r_tail <= squash_ptr_i + PW'(1);
      end else if (w_alloc_fire) begin
        r_tail <= r_tail + w_alloc_cnt;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Entry storage (never reset; head/tail define what is live)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // Ascending port order: the highest port hitting an entry wins.
    for (int p = 0; p < WB_PORTS; p++) begin
      if (w_wb_accept[p]) begin
        r_ent[w_wb_ptr[p][IW-1:0]].complete <= 1'b1;
        r_ent[w_wb_ptr[p][IW-1:0]].excp     <= wb_excp_i[p];
        r_ent[w_wb_ptr[p][IW-1:0]].redirect <= wb_redirect_i[p];
      end
    end
    // Allocation targets [tail, tail+DECODE_WIDTH), disjoint from any
    // accepted write-back, which must lie in [head, tail).
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      if (w_alloc_fire & alloc_valid_i[i]) begin
        r_ent[w_alloc_ptr[i][IW-1:0]] <= '{complete: alloc_excp_i[i],
                                           excp:     alloc_excp_i[i],
                                           redirect: 1'b0,
                                           serial:   alloc_serial_i[i]};
        r_payload[w_alloc_ptr[i][IW-1:0]] <= alloc_payload_i[i*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

`ifdef ROB_WB_DATA_EN
  logic        r_we    [ROB_DEPTH];
  logic [31:0] r_wdata [ROB_DEPTH];

  always_ff @(posedge clk) begin
    for (int p = 0; p < WB_PORTS; p++) begin
      if (w_wb_accept[p]) begin
        r_we[w_wb_ptr[p][IW-1:0]]    <= wb_we_i[p];
        r_wdata[w_wb_ptr[p][IW-1:0]] <= wb_data_i[p*32 +: 32];
      end
    end
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      if (w_alloc_fire & alloc_valid_i[i]) begin
        r_we[w_alloc_ptr[i][IW-1:0]]    <= 1'b0;
        r_wdata[w_alloc_ptr[i][IW-1:0]] <= '0;
      end
    end
  end

  always_comb begin
    cmt_we_o    = '0;
    cmt_wdata_o = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      cmt_we_o[i]             = r_we[w_cmt_idx[i]];
      cmt_wdata_o[i*32 +: 32] = r_wdata[w_cmt_idx[i]];
    end
  end
`else
`endif

  // Allocation slots must be contiguous from bit 0 (value of form 2^k-1).
  assert property (@(posedge clk) disable iff (rst)
                   (alloc_valid_i & (alloc_valid_i + 1'b1)) == '0);

endmodule

// File: tb/tb_rob_multiport.sv
module tb_rob_multiport;

  localparam int D   = 64;
  localparam int DW  = 2;
  localparam int CW  = 2;
  localparam int WP  = 5;
  localparam int PLW = 64;
  localparam int PW  = 7;
  localparam int EW  = PLW + 4;   // {serial, redirect, excp, complete, payload}
  localparam int PM  = 127;       // pointer modulus mask (2*D - 1)

  logic                clk;
  logic                rst;
  logic                flush_i;
  logic [DW-1:0]       alloc_valid_i;
  logic                alloc_ready_i;
  logic [DW*PLW-1:0]   alloc_payload_i;
  logic [DW-1:0]       alloc_excp_i;
  logic [DW-1:0]       alloc_serial_i;
  logic                alloc_ready_o;
  logic [DW*PW-1:0]    alloc_ptr_o;
  logic [WP-1:0]       wb_valid_i;
  logic [WP*PW-1:0]    wb_ptr_i;
  logic [WP-1:0]       wb_excp_i;
  logic [WP-1:0]       wb_redirect_i;
  logic [WP-1:0]       wb_head_only_i;
  logic [WP-1:0]       wb_ready_o;
  logic                squash_valid_i;
  logic [PW-1:0]       squash_ptr_i;
  logic [CW-1:0]       cmt_valid_o;
  logic [CW*PW-1:0]    cmt_ptr_o;
  logic [CW*PLW-1:0]   cmt_payload_o;
  logic [CW-1:0]       cmt_excp_o;
  logic [CW-1:0]       cmt_redirect_o;
  logic [PW-1:0]       count_o;
  logic                empty_o;
`ifdef ROB_WB_DATA_EN
  logic [WP-1:0]       wb_we_i;
  logic [WP*32-1:0]    wb_data_i;
  logic [CW-1:0]       cmt_we_o;
  logic [CW*32-1:0]    cmt_wdata_o;
`endif

  rob_multiport #(
    .ROB_DEPTH    (D),
    .DECODE_WIDTH (DW),
    .COMMIT_WIDTH (CW),
    .WB_PORTS     (WP),
    .PAYLOAD_W    (PLW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .flush_i         (flush_i),
    .alloc_valid_i   (alloc_valid_i),
    .alloc_ready_i   (alloc_ready_i),
    .alloc_payload_i (alloc_payload_i),
    .alloc_excp_i    (alloc_excp_i),
    .alloc_serial_i  (alloc_serial_i),
    .alloc_ready_o   (alloc_ready_o),
    .alloc_ptr_o     (alloc_ptr_o),
    .wb_valid_i      (wb_valid_i),
    .wb_ptr_i        (wb_ptr_i),
    .wb_excp_i       (wb_excp_i),
    .wb_redirect_i   (wb_redirect_i),
    .wb_head_only_i  (wb_head_only_i),
    .wb_ready_o      (wb_ready_o),
    .squash_valid_i  (squash_valid_i),
    .squash_ptr_i    (squash_ptr_i),
    .cmt_valid_o     (cmt_valid_o),
    .cmt_ptr_o       (cmt_ptr_o),
    .cmt_payload_o   (cmt_payload_o),
    .cmt_excp_o      (cmt_excp_o),
    .cmt_redirect_o  (cmt_redirect_o),
    .count_o         (count_o),
    .empty_o         (empty_o)
`ifdef ROB_WB_DATA_EN
    ,
    .wb_we_i         (wb_we_i),
    .wb_data_i       (wb_data_i),
    .cmt_we_o        (cmt_we_o),
    .cmt_wdata_o     (cmt_wdata_o)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  // The ROB is modelled as an in-order queue of live entries; entry k of the
  // queue sits at pointer (m_head + k) mod 2*D.
  logic [EW-1:0] exp_q[$];
  int            m_head;
  bit            m_known;
  int            n_checks;
  int            n_errors;

  function automatic int exp_commit_n();
    int            n;
    logic [EW-1:0] e;
    logic          sp;
    n = 0;
    for (int i = 0; i < CW; i++) begin
      if (i >= exp_q.size()) break;
      e = exp_q[i];
      if (e[PLW] !== 1'b1) break;
      sp = e[PLW+1] | e[PLW+2] | e[PLW+3];
      if (i > 0 && sp) break;
      n++;
      if (sp) break;
    end
    return n;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    flush_i         = 1'b0;
    alloc_valid_i   = '0;
    alloc_ready_i   = 1'b1;
    alloc_payload_i = '0;
    alloc_excp_i    = '0;
    alloc_serial_i  = '0;
    wb_valid_i      = '0;
    wb_ptr_i        = '0;
    wb_excp_i       = '0;
    wb_redirect_i   = '0;
    wb_head_only_i  = '0;
    squash_valid_i  = 1'b0;
    squash_ptr_i    = '0;
`ifdef ROB_WB_DATA_EN
    wb_we_i         = '0;
    wb_data_i       = '0;
`endif
  endtask

  task automatic drive_alloc(input int k, input logic [DW-1:0] ser, input logic [DW-1:0] exc);
    logic [DW-1:0] v;
    v = DW'((1 << k) - 1);
    alloc_valid_i  = v;
    alloc_serial_i = ser & v;
    alloc_excp_i   = exc & v;
    for (int i = 0; i < DW; i++) alloc_payload_i[i*PLW +: PLW] = {$urandom, $urandom};
  endtask

  task automatic drive_wb(input int p, input int ptr, input logic exc, input logic red, input logic ho);
    wb_valid_i[p]         = 1'b1;
    wb_ptr_i[p*PW +: PW]  = PW'(ptr & PM);
    wb_excp_i[p]          = exc;
    wb_redirect_i[p]      = red;
    wb_head_only_i[p]     = ho;
  endtask

  // One clock: compare DUT against the queue model, clock, then advance the
  // model with the inputs that were applied at that edge.
  task automatic scoreboard_cycle();
    int            n, size0, off, ptr, newsize;
    logic [CW-1:0] exp_mask;
    logic [WP-1:0] exp_rdy;
    logic          ready0;
    logic [EW-1:0] e;
    #1;
    if (m_known && !rst) begin
      n = exp_commit_n();
      exp_mask = '0;
      for (int i = 0; i < n; i++) exp_mask[i] = 1'b1;
      n_checks++;
      if (count_o !== PW'(exp_q.size())) begin
        n_errors++; $display("FAIL sb_count: got %0d expected %0d", count_o, exp_q.size());
      end
      n_checks++;
      if (empty_o !== (exp_q.size() == 0)) begin
        n_errors++; $display("FAIL sb_empty: got %0b expected %0b", empty_o, exp_q.size() == 0);
      end
      n_checks++;
      if (alloc_ready_o !== (exp_q.size() <= D - DW)) begin
        n_errors++; $display("FAIL sb_alloc_ready: got %0b expected %0b", alloc_ready_o, exp_q.size() <= D - DW);
      end
      n_checks++;
      if (cmt_valid_o !== exp_mask) begin
        n_errors++; $display("FAIL sb_cmt_valid: got %b expected %b", cmt_valid_o, exp_mask);
      end
      for (int i = 0; i < CW; i++) begin
        n_checks++;
        if (cmt_ptr_o[i*PW +: PW] !== PW'((m_head + i) & PM)) begin
          n_errors++; $display("FAIL sb_cmt_ptr%0d: got %0d expected %0d", i, cmt_ptr_o[i*PW +: PW], (m_head + i) & PM);
        end
      end
      for (int i = 0; i < n; i++) begin
        n_checks++;
        if (cmt_payload_o[i*PLW +: PLW] !== exp_q[i][PLW-1:0] ||
            cmt_excp_o[i] !== exp_q[i][PLW+1] || cmt_redirect_o[i] !== exp_q[i][PLW+2]) begin
          n_errors++;
          $display("FAIL sb_cmt_data%0d: got %h/%0b/%0b expected %h/%0b/%0b", i,
                   cmt_payload_o[i*PLW +: PLW], cmt_excp_o[i], cmt_redirect_o[i],
                   exp_q[i][PLW-1:0], exp_q[i][PLW+1], exp_q[i][PLW+2]);
        end
      end
      for (int i = 0; i < DW; i++) begin
        n_checks++;
        if (alloc_ptr_o[i*PW +: PW] !== PW'((m_head + exp_q.size() + i) & PM)) begin
          n_errors++; $display("FAIL sb_alloc_ptr%0d: got %0d expected %0d", i, alloc_ptr_o[i*PW +: PW], (m_head + exp_q.size() + i) & PM);
        end
      end
      for (int p = 0; p < WP; p++)
        exp_rdy[p] = !wb_head_only_i[p] || (int'(wb_ptr_i[p*PW +: PW]) == m_head);
      n_checks++;
      if (wb_ready_o !== exp_rdy) begin
        n_errors++; $display("FAIL sb_wb_ready: got %b expected %b", wb_ready_o, exp_rdy);
      end
    end
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      m_head  = 0;
      m_known = 1'b1;
    end else if (m_known) begin
      n      = exp_commit_n();
      size0  = exp_q.size();
      ready0 = (size0 <= D - DW);
      for (int p = 0; p < WP; p++) begin
        ptr = int'(wb_ptr_i[p*PW +: PW]);
        if (wb_valid_i[p] && (!wb_head_only_i[p] || ptr == m_head)) begin
          off = (ptr - m_head) & PM;
          if (off < size0) begin
            e = exp_q[off];
            e[PLW]   = 1'b1;
            e[PLW+1] = wb_excp_i[p];
            e[PLW+2] = wb_redirect_i[p];
            exp_q[off] = e;
          end
        end
      end
      repeat (n) void'(exp_q.pop_front());
      m_head = (m_head + n) & PM;
      if (flush_i) begin
        exp_q.delete();
        m_head = 0;
      end else if (squash_valid_i) begin
        newsize = (int'(squash_ptr_i) + 1 - m_head) & PM;
        while (exp_q.size() > newsize) void'(exp_q.pop_back());
      end else if (ready0 && alloc_ready_i) begin
        for (int i = 0; i < DW; i++)
          if (alloc_valid_i[i])
            exp_q.push_back({alloc_serial_i[i], 1'b0, alloc_excp_i[i], alloc_excp_i[i],
                             alloc_payload_i[i*PLW +: PLW]});
      end
    end
    @(negedge clk);
  endtask

  task automatic do_flush();
    clear_inputs();
    flush_i = 1'b1;
    scoreboard_cycle();
    flush_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    scoreboard_cycle();
    scoreboard_cycle();
    rst = 1'b0;
    #1;
    n_checks++;
    if (count_o !== 7'd0 || empty_o !== 1'b1) begin
      n_errors++; $display("FAIL reset_count: got %0d/%0b expected 0/1", count_o, empty_o);
    end
    n_checks++;
    if (cmt_valid_o !== 2'b00 || alloc_ready_o !== 1'b1) begin
      n_errors++; $display("FAIL reset_ctrl: got cmt=%b rdy=%0b expected 00/1", cmt_valid_o, alloc_ready_o);
    end
    n_checks++;
    if (alloc_ptr_o !== {7'd1, 7'd0}) begin
      n_errors++; $display("FAIL reset_alloc_ptr: got %h expected %h", alloc_ptr_o, {7'd1, 7'd0});
    end
    scoreboard_cycle();
  endtask

  task automatic test_fill();
    do_flush();
    for (int c = 0; c < 32; c++) begin
      drive_alloc(2, '0, '0);
      if (c == 31) begin
        #1;
        n_checks++;
        if (alloc_ready_o !== 1'b1 || count_o !== 7'd62) begin
          n_errors++; $display("FAIL fill_62: got cnt=%0d rdy=%0b expected 62/1", count_o, alloc_ready_o);
        end
      end
      scoreboard_cycle();
    end
    n_checks++;
    if (count_o !== 7'd64 || alloc_ready_o !== 1'b0 || cmt_valid_o !== 2'b00 || empty_o !== 1'b0) begin
      n_errors++;
      $display("FAIL fill_full: got cnt=%0d rdy=%0b cmt=%b expected 64/0/00", count_o, alloc_ready_o, cmt_valid_o);
    end
    drive_alloc(2, '0, '0);
    scoreboard_cycle();
    n_checks++;
    if (count_o !== 7'd64) begin
      n_errors++; $display("FAIL fill_hold: got %0d expected 64", count_o);
    end
    do_flush();
  endtask

  task automatic test_wb_order();
    do_flush();
    drive_alloc(2, '0, '0); scoreboard_cycle();
    drive_alloc(2, '0, '0); scoreboard_cycle();
    clear_inputs();
    drive_wb(0, 1, 1'b0, 1'b0, 1'b0); scoreboard_cycle();
    n_checks++;
    if (cmt_valid_o !== 2'b00) begin
      n_errors++; $display("FAIL wb_order_1: got %b expected 00", cmt_valid_o);
    end
    clear_inputs();
    drive_wb(0, 0, 1'b0, 1'b0, 1'b0); scoreboard_cycle();
    n_checks++;
    if (cmt_valid_o !== 2'b11 || cmt_ptr_o[PW +: PW] !== 7'd1) begin
      n_errors++; $display("FAIL wb_order_0: got %b ptr1=%0d expected 11/1", cmt_valid_o, cmt_ptr_o[PW +: PW]);
    end
    clear_inputs();
    drive_wb(0, 3, 1'b0, 1'b0, 1'b0); scoreboard_cycle();
    n_checks++;
    if (cmt_valid_o !== 2'b00 || count_o !== 7'd2) begin
      n_errors++; $display("FAIL wb_order_3: got %b cnt=%0d expected 00/2", cmt_valid_o, count_o);
    end
    clear_inputs();
    drive_wb(0, 2, 1'b0, 1'b0, 1'b0); scoreboard_cycle();
    n_checks++;
    if (cmt_valid_o !== 2'b11 || cmt_ptr_o[PW-1:0] !== 7'd2) begin
      n_errors++; $display("FAIL wb_order_2: got %b ptr0=%0d expected 11/2", cmt_valid_o, cmt_ptr_o[PW-1:0]);
    end
    clear_inputs(); scoreboard_cycle();
    n_checks++;
    if (empty_o !== 1'b1) begin
      n_errors++; $display("FAIL wb_order_drain: got empty=%0b expected 1", empty_o);
    end
  endtask

  task automatic test_serial();
    do_flush();
    drive_alloc(2, 2'b01, 2'b00); scoreboard_cycle();
    clear_inputs();
    drive_wb(0, 0, 1'b0, 1'b0, 1'b0);
    drive_wb(1, 1, 1'b0, 1'b0, 1'b0);
    scoreboard_cycle();
    n_checks++;
    if (cmt_valid_o !== 2'b01 || cmt_ptr_o[PW-1:0] !== 7'd0) begin
      n_errors++; $display("FAIL serial_c1: got %b ptr0=%0d expected 01/0", cmt_valid_o, cmt_ptr_o[PW-1:0]);
    end
    clear_inputs(); scoreboard_cycle();
    n_checks++;
    if (cmt_valid_o !== 2'b01 || cmt_ptr_o[PW-1:0] !== 7'd1) begin
      n_errors++; $display("FAIL serial_c2: got %b ptr0=%0d expected 01/1", cmt_valid_o, cmt_ptr_o[PW-1:0]);
    end
    scoreboard_cycle();
  endtask

  task automatic test_squash();
    do_flush();
    for (int c = 0; c < 5; c++) begin
      drive_alloc(2, '0, '0); scoreboard_cycle();
    end
    squash_valid_i = 1'b1;
    squash_ptr_i   = 7'd3;
    drive_alloc(2, '0, '0);
    scoreboard_cycle();
    n_checks++;
    if (count_o !== 7'd4 || alloc_ptr_o[PW-1:0] !== 7'd4) begin
      n_errors++; $display("FAIL squash_tail: got cnt=%0d tail=%0d expected 4/4", count_o, alloc_ptr_o[PW-1:0]);
    end
    clear_inputs();
    drive_wb(0, 7, 1'b0, 1'b0, 1'b0); scoreboard_cycle();
    clear_inputs();
    drive_alloc(2, '0, '0); scoreboard_cycle();
    drive_alloc(2, '0, '0); scoreboard_cycle();
    clear_inputs();
    for (int p = 0; p < WP; p++) drive_wb(p, p, 1'b0, 1'b0, 1'b0);
    scoreboard_cycle();
    clear_inputs();
    drive_wb(0, 5, 1'b0, 1'b0, 1'b0);
    drive_wb(1, 6, 1'b0, 1'b0, 1'b0);
    scoreboard_cycle();
    clear_inputs();
    repeat (5) scoreboard_cycle();
    n_checks++;
    if (count_o !== 7'd1 || cmt_valid_o !== 2'b00) begin
      n_errors++; $display("FAIL squash_stale_wb: got cnt=%0d cmt=%b expected 1/00", count_o, cmt_valid_o);
    end
    do_flush();
  endtask

  task automatic test_head_only();
    do_flush();
    drive_alloc(2, '0, '0); scoreboard_cycle();
    drive_alloc(2, '0, '0); scoreboard_cycle();
    clear_inputs();
    drive_wb(0, 2, 1'b0, 1'b0, 1'b1);
    drive_wb(1, 0, 1'b0, 1'b0, 1'b0);
    drive_wb(2, 1, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (wb_ready_o[0] !== 1'b0) begin
      n_errors++; $display("FAIL head_only_blocked: got %0b expected 0", wb_ready_o[0]);
    end
    scoreboard_cycle();
    wb_valid_i[2:1] = 2'b00;
    #1;
    n_checks++;
    if (wb_ready_o[0] !== 1'b0 || cmt_valid_o !== 2'b11) begin
      n_errors++; $display("FAIL head_only_wait: got rdy=%0b cmt=%b expected 0/11", wb_ready_o[0], cmt_valid_o);
    end
    scoreboard_cycle();
    n_checks++;
    if (wb_ready_o[0] !== 1'b1 || count_o !== 7'd2) begin
      n_errors++; $display("FAIL head_only_ready: got rdy=%0b cnt=%0d expected 1/2", wb_ready_o[0], count_o);
    end
    scoreboard_cycle();
    clear_inputs();
    #1;
    n_checks++;
    if (cmt_valid_o[0] !== 1'b1 || cmt_ptr_o[PW-1:0] !== 7'd2) begin
      n_errors++; $display("FAIL head_only_commit: got %b ptr0=%0d expected x1/2", cmt_valid_o, cmt_ptr_o[PW-1:0]);
    end
    scoreboard_cycle();
    do_flush();
  endtask

  task automatic test_random();
    int size, n, off, k;
    do_flush();
    for (int c = 0; c < 400; c++) begin
      size = exp_q.size();
      n    = exp_commit_n();
      clear_inputs();
      k = $urandom_range(0, 2);
      drive_alloc(k, DW'(($urandom_range(0, 9) == 0) ? 1 : 0) | DW'(($urandom_range(0, 9) == 0) ? 2 : 0),
                  DW'(($urandom_range(0, 19) == 0) ? 1 : 0));
      alloc_ready_i = ($urandom_range(0, 7) != 0);
      for (int p = 0; p < WP; p++) begin
        if ($urandom_range(0, 3) != 0) begin
          off = ($urandom_range(0, 9) == 0) ? size + p : (($urandom_range(0, 1) == 1) ? p : p + 5);
          drive_wb(p, m_head + off, $urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0,
                   $urandom_range(0, 7) == 0);
        end
      end
      if (c == 200) begin
        flush_i = 1'b1;
      end else if (size > n && $urandom_range(0, 24) == 0) begin
        squash_valid_i = 1'b1;
        squash_ptr_i   = PW'((m_head + $urandom_range(n, size - 1)) & PM);
      end
      scoreboard_cycle();
      if (c == 200) begin
        n_checks++;
        if (count_o !== 7'd0 || alloc_ptr_o[PW-1:0] !== 7'd0) begin
          n_errors++; $display("FAIL random_flush: got cnt=%0d ptr0=%0d expected 0/0", count_o, alloc_ptr_o[PW-1:0]);
        end
      end
    end
    clear_inputs();
    scoreboard_cycle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    m_known  = 1'b0;
    m_head   = 0;
    rst      = 1'b1;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_fill();
    test_wb_order();
    test_serial();
    test_squash();
    test_head_only();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
